// File: rtl/sram_arbiter_2to1.sv
// Two-client arbiter in front of a 1R1W SRAM: independent round-robin read and
// write ports, read-after-write hazard stall, and read-data return routing.
module sram_arbiter_2to1 #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              c0RdReq,
    input  logic              c1RdReq,
    input  logic [ADDR_W-1:0] c0RdAddr,
    input  logic [ADDR_W-1:0] c1RdAddr,
    output logic              c0RdGnt,
    output logic              c1RdGnt,
    output logic              c0RdValid,
    output logic              c1RdValid,
    output logic [DATA_W-1:0] c0RdData,
    output logic [DATA_W-1:0] c1RdData,
    input  logic              c0WrReq,
    input  logic              c1WrReq,
    input  logic [ADDR_W-1:0] c0WrAddr,
    input  logic [ADDR_W-1:0] c1WrAddr,
    input  logic [DATA_W-1:0] c0WrData,
    input  logic [DATA_W-1:0] c1WrData,
    output logic              c0WrGnt,
    output logic              c1WrGnt,
    output logic [ADDR_W-1:0] ReadAddress,
    input  logic [DATA_W-1:0] ReadBus,
    output logic              WE,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [DATA_W-1:0] WriteBus
);

    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_sel0, rd_sel1;
    logic              hazard0, hazard1;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // Write port arbitration and SRAM write drive
    always_comb begin
        c0WrGnt      = rst_n & c0WrReq & (~c1WrReq | ~wr_ptr_q);
        c1WrGnt      = rst_n & c1WrReq & (~c0WrReq |  wr_ptr_q);
        WE           = c0WrGnt | c1WrGnt;
        WriteAddress = '0;
        WriteBus     = '0;
        wr_ptr_d     = wr_ptr_q;
        if (c0WrGnt) begin
            WriteAddress = c0WrAddr;
            WriteBus     = c0WrData;
            wr_ptr_d     = 1'b1;
        end else if (c1WrGnt) begin
            WriteAddress = c1WrAddr;
            WriteBus     = c1WrData;
            wr_ptr_d     = 1'b0;
        end
    end

    // Read port arbitration; a read colliding with this cycle's write is held off
    always_comb begin
        rd_sel0     = c0RdReq & (~c1RdReq | ~rd_ptr_q);
        rd_sel1     = c1RdReq & (~c0RdReq |  rd_ptr_q);
        hazard0     = WE && (WriteAddress == c0RdAddr);
        hazard1     = WE && (WriteAddress == c1RdAddr);
        c0RdGnt     = rst_n & rd_sel0 & ~hazard0;
        c1RdGnt     = rst_n & rd_sel1 & ~hazard1;
        ReadAddress = rd_addr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_owner_d  = rd_owner_q;
        rd_pend_d   = c0RdGnt | c1RdGnt;
        if (c0RdGnt) begin
            ReadAddress = c0RdAddr;
            rd_ptr_d    = 1'b1;
            rd_owner_d  = 1'b0;
        end else if (c1RdGnt) begin
            ReadAddress = c1RdAddr;
            rd_ptr_d    = 1'b0;
            rd_owner_d  = 1'b1;
        end
        rd_addr_d = ReadAddress;
    end

    // Return data goes only to the client that owned last cycle's grant
    always_comb begin
        c0RdValid = rst_n & rd_pend_q & ~rd_owner_q;
        c1RdValid = rst_n & rd_pend_q &  rd_owner_q;
        c0RdData  = c0RdValid ? ReadBus : '0;
        c1RdData  = c1RdValid ? ReadBus : '0;
    end

endmodule
